// File: rtl/instr_decoder_pkg.sv
// rtl/instr_decoder_pkg.sv - shared RV32 decode constants, opcodes and format enum
package instr_decoder_pkg;

  localparam int WORD_SIZE           = 32;
  localparam int ARCH_REG_INDEX_SIZE = 5;

  localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;

  localparam logic [6:0] ADD_OR_AND_FUNCT7 = 7'b0000000;
  localparam logic [6:0] SUB_FUNCT7        = 7'b0100000;
  localparam logic [6:0] MUL_FUNCT7        = 7'b0000001;

  localparam logic [2:0] ADD_FUNCT3  = 3'b000;
  localparam logic [2:0] ADDI_FUNCT3 = 3'b000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_t;

endpackage

// File: rtl/instr_decoder_imm_gen.sv
// rtl/instr_decoder_imm_gen.sv - combinational sign-extended immediate per instruction format
module imm_gen
  import instr_decoder_pkg::*;
(
  input  logic [WORD_SIZE-1:7] instr,
  input  fmt_t                 fmt,
  output logic [WORD_SIZE-1:0] imm
);

  // B and J offsets stay PC-relative; the branch unit adds the PC.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - registered RV32 decode: format, fields, immediate, illegal flag
// Optional M-extension multiply legality under DECODER_MEXT_EN.
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter int INSTR_SIZE = WORD_SIZE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           instr_valid,
  input  logic                           stall,
  input  logic [INSTR_SIZE-1:0]          instr,
  output logic                           valid,
  output logic [ARCH_REG_INDEX_SIZE-1:0] rs1,
  output logic [ARCH_REG_INDEX_SIZE-1:0] rs2,
  output logic [ARCH_REG_INDEX_SIZE-1:0] rd,
  output logic [WORD_SIZE-1:0]           imm,
  output logic [6:0]                     opcode,
  output logic [2:0]                     funct3,
  output logic [6:0]                     funct7,
  output logic                           instr_R_type,
  output logic                           instr_I_type,
  output logic                           instr_S_type,
  output logic                           instr_B_type,
  output logic                           instr_U_type,
  output logic                           instr_J_type,
  output logic                           illegal
);

  logic [6:0] op;
  logic [6:0] f7;
  logic       mul_ok;
  fmt_t       fmt;
  logic [WORD_SIZE-1:0] d_imm;
  logic [ARCH_REG_INDEX_SIZE-1:0] d_rs1, d_rs2, d_rd;

  assign op = instr[6:0];
  assign f7 = instr[31:25];

`ifdef DECODER_MEXT_EN
  assign mul_ok = (f7 == MUL_FUNCT7);
`else
  assign mul_ok = 1'b0;
`endif

  always_comb begin
    fmt = FMT_ILLEGAL;
    case (op)
      OPCODE_ALU: begin
        if (f7 == ADD_OR_AND_FUNCT7 || f7 == SUB_FUNCT7 || mul_ok)
          fmt = FMT_R;
      end
      OPCODE_ALU_IMM, OPCODE_LOAD, OPCODE_JALR: fmt = FMT_I;
      OPCODE_STORE:                             fmt = FMT_S;
      OPCODE_BRANCH:                            fmt = FMT_B;
      OPCODE_AUIPC, OPCODE_LUI:                 fmt = FMT_U;
      OPCODE_JUMP:                              fmt = FMT_J;
      default:                                  fmt = FMT_ILLEGAL;
    endcase
  end

  // Unused register fields are forced to 0 so rename never sees phantom dependencies.
  assign d_rs1 = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) ? instr[19:15] : '0;
  assign d_rs2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? instr[24:20] : '0;
  assign d_rd  = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? instr[11:7] : '0;

  imm_gen u_imm_gen (
    .instr (instr[WORD_SIZE-1:7]),
    .fmt   (fmt),
    .imm   (d_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid        <= 1'b0;
      rs1          <= '0;
      rs2          <= '0;
      rd           <= '0;
      imm          <= '0;
      opcode       <= '0;
      funct3       <= '0;
      funct7       <= '0;
      instr_R_type <= 1'b0;
      instr_I_type <= 1'b0;
      instr_S_type <= 1'b0;
      instr_B_type <= 1'b0;
      instr_U_type <= 1'b0;
      instr_J_type <= 1'b0;
      illegal      <= 1'b0;
    end else if (!stall) begin
      valid        <= instr_valid;
      rs1          <= d_rs1;
      rs2          <= d_rs2;
      rd           <= d_rd;
      imm          <= d_imm;
      opcode       <= op;
      funct3       <= instr[14:12];
      funct7       <= f7;
      instr_R_type <= (fmt == FMT_R);
      instr_I_type <= (fmt == FMT_I);
      instr_S_type <= (fmt == FMT_S);
      instr_B_type <= (fmt == FMT_B);
      instr_U_type <= (fmt == FMT_U);
      instr_J_type <= (fmt == FMT_J);
      illegal      <= (fmt == FMT_ILLEGAL);
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - scoreboard bench for instr_decoder with directed RV32 vectors
module tb_instr_decoder;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        stall;
  logic [31:0] instr;
  logic        valid;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_R_type, instr_I_type, instr_S_type;
  logic        instr_B_type, instr_U_type, instr_J_type;
  logic        illegal;

  instr_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .instr        (instr),
    .valid        (valid),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .imm          (imm),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .instr_R_type (instr_R_type),
    .instr_I_type (instr_I_type),
    .instr_S_type (instr_S_type),
    .instr_B_type (instr_B_type),
    .instr_U_type (instr_U_type),
    .instr_J_type (instr_J_type),
    .illegal      (illegal)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  flags;
    logic        ill;
  } exp_t;

  localparam logic [5:0] F_R = 6'b100000;
  localparam logic [5:0] F_I = 6'b010000;
  localparam logic [5:0] F_S = 6'b001000;
  localparam logic [5:0] F_B = 6'b000100;
  localparam logic [5:0] F_U = 6'b000010;
  localparam logic [5:0] F_J = 6'b000001;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic captured = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A new result is presented only when the preceding edge was a live capture.
  always @(posedge clk) captured <= rst_n && !stall;

  always @(negedge clk) begin
    exp_t e;
    if (captured && valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no pending instruction");
      end else begin
        e = q.pop_front();
        chk($sformatf("rs1[%08h]", e.w), {27'd0, rs1}, {27'd0, e.rs1});
        chk($sformatf("rs2[%08h]", e.w), {27'd0, rs2}, {27'd0, e.rs2});
        chk($sformatf("rd[%08h]", e.w), {27'd0, rd}, {27'd0, e.rd});
        chk($sformatf("imm[%08h]", e.w), imm, e.imm);
        chk($sformatf("opcode[%08h]", e.w), {25'd0, opcode}, {25'd0, e.w[6:0]});
        chk($sformatf("funct3[%08h]", e.w), {29'd0, funct3}, {29'd0, e.w[14:12]});
        chk($sformatf("funct7[%08h]", e.w), {25'd0, funct7}, {25'd0, e.w[31:25]});
        chk($sformatf("flags[%08h]", e.w),
            {26'd0, instr_R_type, instr_I_type, instr_S_type, instr_B_type, instr_U_type, instr_J_type},
            {26'd0, e.flags});
        chk($sformatf("illegal[%08h]", e.w), {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic issue(input logic [31:0] w, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                       input logic [4:0] e_rd, input logic [31:0] e_imm, input logic [5:0] e_flags,
                       input logic e_ill);
    exp_t e;
    e = '{w: w, rs1: e_rs1, rs2: e_rs2, rd: e_rd, imm: e_imm, flags: e_flags, ill: e_ill};
    instr       = w;
    instr_valid = 1'b1;
    stall       = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs_or();
    return {27'd0, rs1} | {27'd0, rs2} | {27'd0, rd} | imm | {25'd0, opcode} | {29'd0, funct3}
         | {25'd0, funct7} | {31'd0, valid | illegal | instr_R_type | instr_I_type | instr_S_type
         | instr_B_type | instr_U_type | instr_J_type};
  endfunction

  initial begin
    rst_n       = 1'b0;
    instr       = 32'h0000_007f;
    instr_valid = 1'b1;
    stall       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_all_outputs", all_outputs_or(), 32'd0);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h003100b3, 5'd2, 5'd3, 5'd1,  32'd0,        F_R, 1'b0);
    issue(32'h40418133, 5'd3, 5'd4, 5'd2,  32'd0,        F_R, 1'b0);
    issue(32'h00108093, 5'd1, 5'd0, 5'd1,  32'd1,        F_I, 1'b0);
    issue(32'h00118083, 5'd3, 5'd0, 5'd1,  32'd1,        F_I, 1'b0);
    issue(32'h0011a083, 5'd3, 5'd0, 5'd1,  32'd1,        F_I, 1'b0);
    issue(32'hfff00093, 5'd0, 5'd0, 5'd1,  32'hffffffff, F_I, 1'b0);
    issue(32'h000080e7, 5'd1, 5'd0, 5'd1,  32'd0,        F_I, 1'b0);
    issue(32'h001180a3, 5'd3, 5'd1, 5'd0,  32'd1,        F_S, 1'b0);
    issue(32'h0011a0a3, 5'd3, 5'd1, 5'd0,  32'd1,        F_S, 1'b0);
    issue(32'hff5ff06f, 5'd0, 5'd0, 5'd0,  32'hfffffff4, F_J, 1'b0);
    issue(32'hff1ff0ef, 5'd0, 5'd0, 5'd1,  32'hfffffff0, F_J, 1'b0);
    issue(32'hfe1084e3, 5'd1, 5'd1, 5'd0,  32'hffffffe8, F_B, 1'b0);
    issue(32'h00008517, 5'd0, 5'd0, 5'd10, 32'h00008000, F_U, 1'b0);
    issue(32'h12345537, 5'd0, 5'd0, 5'd10, 32'h12345000, F_U, 1'b0);
`ifdef DECODER_MEXT_EN
    issue(32'h02418133, 5'd3, 5'd4, 5'd2,  32'd0,        F_R, 1'b0);
`else
    issue(32'h02418133, 5'd0, 5'd0, 5'd0,  32'd0,        6'd0, 1'b1);
`endif
    issue(32'h60418133, 5'd0, 5'd0, 5'd0,  32'd0,        6'd0, 1'b1);
    issue(32'h0000007f, 5'd0, 5'd0, 5'd0,  32'd0,        6'd0, 1'b1);

    instr_valid = 1'b0;
    instr       = 32'h00108093;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("valid_drops", {31'd0, valid}, 32'd0);

    issue(32'h003100b3, 5'd2, 5'd3, 5'd1, 32'd0, F_R, 1'b0);
    stall       = 1'b1;
    instr       = 32'hfe1084e3;
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", i), {31'd0, valid}, 32'd1);
      chk($sformatf("stall_rd_%0d", i), {27'd0, rd}, 32'd1);
      chk($sformatf("stall_rs2_%0d", i), {27'd0, rs2}, 32'd3);
      chk($sformatf("stall_R_%0d", i), {31'd0, instr_R_type}, 32'd1);
      instr = instr ^ 32'h0000_0f00;
    end
    stall = 1'b0;
    @(posedge clk);
    #1;

    issue(32'h00108093, 5'd1, 5'd0, 5'd1, 32'd1, F_I, 1'b0);
    instr_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_all_outputs", all_outputs_or(), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h00008517, 5'd0, 5'd0, 5'd10, 32'h00008000, F_U, 1'b0);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
